// File: rtl/whackamole_pkg.sv
// Shared constants and helpers for the whack-a-mole tile (button front-end and game core).
package whackamole_pkg;

    // Default number of buttons / mole positions.
    localparam int N_BTN_DEF           = 4;
    // Default number of cycles a synchronized level must hold before acceptance.
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Width of a button index; never below one bit so ports stay legal.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of the debounce counter, which counts up to cycles-1.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/whackamole_debounce.sv
// One button line: two-flop synchronizer followed by a counter-based debouncer.
module whackamole_debounce
    import whackamole_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0_q;
    logic             sync1_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchronizer flops and debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q  <= 1'b0;
            sync1_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync0_q  <= btn_raw;
            sync1_q  <= sync0_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Count how long the synchronized level has disagreed with the accepted level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync1_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync1_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign level = stable_q;

endmodule

// File: rtl/whackamole_button_rx.sv
// Button return path: debounce every line, queue presses, hand out one hit at a time.
module whackamole_button_rx
    import whackamole_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_BTN-1:0]            btn_raw,
    input  logic                        arm,
    input  logic                        flush,
    input  logic                        hit_ready,
    output logic                        hit_valid,
    output logic [idx_width(N_BTN)-1:0] hit_idx,
    output logic [N_BTN-1:0]            btn_level,
    output logic                        ovf,
    input  logic                        ovf_clr
);

    localparam int IDX_W = idx_width(N_BTN);

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] pending_q;
    logic [N_BTN-1:0] pending_d;
    logic             hit_valid_q;
    logic             hit_valid_d;
    logic [IDX_W-1:0] hit_idx_q;
    logic [IDX_W-1:0] hit_idx_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [N_BTN-1:0] press_armed;
    logic [N_BTN-1:0] load_mask;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             load;
    logic             ovf_set;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            whackamole_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .btn_raw (btn_raw[gi]),
                .level   (level[gi])
            );
        end
    endgenerate

    // Lowest-index pending press wins the output register.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

    // Pending vector, output register and overflow next-state.
    always_comb begin
        press_armed = arm ? (level & ~level_q) : '0;
        load        = ~hit_valid_q | hit_ready;
        load_mask   = (load && pick_found) ? (N_BTN'(1) << pick_idx) : '0;
        pending_d   = pending_q;
        hit_valid_d = hit_valid_q;
        hit_idx_d   = hit_idx_q;
        ovf_set     = 1'b0;
        if (flush) begin
            // Flush drops everything queued, including a press arriving now.
            pending_d   = '0;
            hit_valid_d = 1'b0;
        end else begin
            // A bit being loaded this cycle is free again, so a new press there is not lost.
            pending_d = (pending_q & ~load_mask) | press_armed;
            ovf_set   = |(press_armed & pending_q & ~load_mask);
            if (load) begin
                hit_valid_d = pick_found;
                if (pick_found) begin
                    hit_idx_d = pick_idx;
                end
            end
        end
        ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    // Edge-detect history, queue and output state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q     <= '0;
            pending_q   <= '0;
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            level_q     <= level;
            pending_q   <= pending_d;
            hit_valid_q <= hit_valid_d;
            hit_idx_q   <= hit_idx_d;
            ovf_q       <= ovf_d;
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit_idx   = hit_idx_q;
    assign btn_level = level;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_whackamole_button_rx.sv
// Directed bench for whackamole_button_rx with an event scoreboard on the hit handshake.
module tb_whackamole_button_rx;

    localparam int N_BTN = 4;
    localparam int D     = 4;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] btn_raw;
    logic             arm;
    logic             flush;
    logic             hit_ready;
    logic             hit_valid;
    logic [1:0]       hit_idx;
    logic [N_BTN-1:0] btn_level;
    logic             ovf;
    logic             ovf_clr;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    whackamole_button_rx #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .arm       (arm),
        .flush     (flush),
        .hit_ready (hit_ready),
        .hit_valid (hit_valid),
        .hit_idx   (hit_idx),
        .btn_level (btn_level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completed handshake must match the oldest expected index.
    always @(negedge clk) begin
        if (!rst && hit_valid && hit_ready) begin
            $display("event idx=%0d queued=%0d", hit_idx, exp_q.size());
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_event observed idx=%0d expected=none", hit_idx);
            end
            if (exp_q.size() > 0) check("event_idx", 32'(hit_idx), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; btn_raw = '0; arm = 1'b1; flush = 1'b0; hit_ready = 1'b1; ovf_clr = 1'b0;
        tick(3);
        check("rst_valid", hit_valid, 1'b0);
        check("rst_idx", hit_idx, 2'd0);
        check("rst_level", btn_level, 4'h0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        tick(2);

        // Single press of button 2 with the core ready.
        exp_q.push_back(2);
        btn_raw[2] = 1'b1;
        tick(5);
        check("lvl2_edge4", btn_level[2], 1'b0);
        tick(1);
        check("lvl2_edge5", btn_level[2], 1'b1);
        tick(1);
        check("valid_edge6", hit_valid, 1'b0);
        tick(1);
        check("valid_edge7", hit_valid, 1'b1);
        check("idx_edge7", hit_idx, 2'd2);
        tick(1);
        check("valid_edge8", hit_valid, 1'b0);
        btn_raw[2] = 1'b0;
        tick(10);
        check("release_lvl2", btn_level[2], 1'b0);
        check("release_noevent", hit_valid, 1'b0);

        // Three-cycle glitch on button 1 is filtered out.
        btn_raw[1] = 1'b1;
        tick(3);
        btn_raw[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("glitch_lvl1", btn_level[1], 1'b0);
        end

        // Simultaneous presses on 0 and 3 while stalled.
        hit_ready = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(3);
        btn_raw = 4'b1001;
        tick(8);
        check("dual_valid", hit_valid, 1'b1);
        check("dual_idx0", hit_idx, 2'd0);
        tick(2);
        check("dual_hold_idx", hit_idx, 2'd0);
        check("dual_hold_valid", hit_valid, 1'b1);
        hit_ready = 1'b1;
        tick(1);
        check("dual_idx3", hit_idx, 2'd3);
        check("dual_valid3", hit_valid, 1'b1);
        tick(1);
        check("dual_empty", hit_valid, 1'b0);
        btn_raw = '0;
        tick(10);

        // All four at once drain back-to-back in index order.
        hit_ready = 1'b0;
        for (int k = 0; k < N_BTN; k++) exp_q.push_back(k);
        btn_raw = 4'hF;
        tick(8);
        check("drain_idx0", hit_idx, 2'd0);
        hit_ready = 1'b1;
        tick(1);
        check("drain_idx1", hit_idx, 2'd1);
        tick(1);
        check("drain_idx2", hit_idx, 2'd2);
        tick(1);
        check("drain_idx3", hit_idx, 2'd3);
        tick(1);
        check("drain_empty", hit_valid, 1'b0);
        btn_raw = '0;
        tick(10);

        // Overflow: output busy, one pending, third press is lost.
        hit_ready = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(1);
        for (int p = 0; p < 3; p++) begin
            btn_raw[1] = 1'b1;
            tick(10);
            btn_raw[1] = 1'b0;
            tick(10);
            check("ovf_after_press", ovf, (p == 2) ? 1'b1 : 1'b0);
            check("ovf_out_valid", hit_valid, 1'b1);
            check("ovf_out_idx", hit_idx, 2'd1);
        end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf, 1'b0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        exp_q.delete();
        check("flush_valid", hit_valid, 1'b0);
        hit_ready = 1'b1;
        tick(5);
        check("flush_no_pending", hit_valid, 1'b0);

        // Disarmed press is dropped; arming while held does not create one.
        arm = 1'b0;
        btn_raw[2] = 1'b1;
        tick(8);
        check("disarm_level", btn_level[2], 1'b1);
        check("disarm_noevent", hit_valid, 1'b0);
        arm = 1'b1;
        tick(6);
        check("arm_held_noevent", hit_valid, 1'b0);
        check("disarm_ovf", ovf, 1'b0);
        btn_raw[2] = 1'b0;
        tick(8);
        check("disarm_release", btn_level[2], 1'b0);
        exp_q.push_back(2);
        btn_raw[2] = 1'b1;
        tick(8);
        check("repress_valid", hit_valid, 1'b1);
        check("repress_idx", hit_idx, 2'd2);
        btn_raw[2] = 1'b0;
        tick(8);

        // Asynchronous reset while events are queued and stalled.
        hit_ready = 1'b0;
        btn_raw = 4'b1001;
        tick(10);
        check("pre_rst_valid", hit_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", hit_valid, 1'b0);
        check("async_rst_idx", hit_idx, 2'd0);
        check("async_rst_level", btn_level, 4'h0);
        check("async_rst_ovf", ovf, 1'b0);
        btn_raw = '0;
        tick(2);
        rst = 1'b0;
        hit_ready = 1'b1;
        tick(15);
        check("post_rst_noevent", hit_valid, 1'b0);
        exp_q.push_back(3);
        btn_raw[3] = 1'b1;
        tick(8);
        check("post_rst_valid", hit_valid, 1'b1);
        check("post_rst_idx", hit_idx, 2'd3);
        btn_raw[3] = 1'b0;
        tick(10);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/whackamole_button_rx.md
# whackamole_button_rx

Input front-end of the whack-a-mole tile: takes the raw player push-button lines, synchronizes and debounces each one, and converts presses into indexed hit events for the game core. The game core drives the mole LEDs; this block is the return path. It delivers one hit at a time over a valid/ready handshake and buffers simultaneous presses so none is lost silently.

## Interface
Parameters:
- `N_BTN`, 4: number of buttons/mole positions (2..8).
- `DEBOUNCE_CYCLES`, 4: cycles a synchronized level must stay unchanged before it is accepted (≥1).

Ports:
- `clk`  in  1  tile clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_raw`  in  N_BTN  raw buttons, active-high, asynchronous to `clk`.
- `arm`  in  1  1 = presses are recorded; 0 = presses discarded.
- `flush`  in  1  synchronous clear of pending presses and output event.
- `hit_ready`  in  1  game core accepts the event.
- `hit_valid`  out  1  event available.
- `hit_idx`  out  $clog2(N_BTN)  button index of the event.
- `btn_level`  out  N_BTN  debounced button levels.
- `ovf`  out  1  sticky: a press was lost.
- `ovf_clr`  in  1  synchronous clear of `ovf`.

## Operation
- Per button: 2-flop synchronizer → debouncer → registered edge detect.
- Debouncer: counter cleared while sync == stable; otherwise increments; when sync != stable and count == DEBOUNCE_CYCLES-1, stable <= sync and counter clears. `btn_level` = stable.
- Press = stable & ~stable_q (rising edge only; releases produce no event).
- Press with `arm`=1 sets `pending[i]`; with `arm`=0 it is dropped, and `ovf` is unaffected.
- Output register (`hit_valid`, `hit_idx`) loads lowest-index set pending bit when empty or when handshake (valid & ready) completes the same cycle; that pending bit clears on load.
- `hit_valid`/`hit_idx` held stable until `hit_ready`; no change while stalled.
- Overflow: a press on i while `pending[i]` is already set and not being loaded this cycle → `ovf` <= 1; the press is merged (pending stays 1). The same index in the output register does not count as pending.
- `flush`: pending <= 0, `hit_valid` <= 0; debounce state untouched; a press in the same cycle is discarded. `ovf_clr` and a simultaneous overflow → `ovf` = 1 (set wins).
- Reset: all sync flops, stable levels, counters, pending, `hit_valid`, `hit_idx`, `ovf` = 0; `btn_level` = 0.

## Timing
- Edge 0 = first rising edge sampling `btn_raw[i]` high, held stable: `btn_level[i]` high after edge DEBOUNCE_CYCLES+1; `pending[i]` after edge D+2; `hit_valid` after edge D+3 (empty queue).
- Release latency on `btn_level` is the same D+1 edges.
- Pulses shorter than D cycles after synchronization never change `btn_level`.
- Back-to-back: with `hit_ready`=1, one event per cycle drains from pending.
- Reset mid-operation clears immediately (async); the first event after deassertion requires a fresh press.

## Structure
- `whackamole_pkg`: default `N_BTN`, `DEBOUNCE_CYCLES`, index-width localparam/function, shared with the game core.
- Sub-module `whackamole_debounce` (sync + counter + stable level for one line), generate-instantiated N_BTN times; the priority pick, pending vector, output register and `ovf` live in the top module.

## Test plan
(N_BTN=4, D=4.)
- Reset asserted mid-run with pending events → all outputs 0 immediately; no event after release until a new press.
- `btn_raw[2]` high at edge 0, `hit_ready`=1 → `btn_level[2]`=1 after edge 5, `hit_valid`=1/`hit_idx`=2 after edge 7 for exactly one cycle; release yields no event.
- `btn_raw[1]` high for 3 cycles then low → `btn_level` stays 0, no `hit_valid`.
- `btn_raw[0]` and `btn_raw[3]` rise together, `hit_ready`=0 → `hit_idx`=0 held; raise `hit_ready` → next cycle `hit_idx`=3, following cycle `hit_valid`=0.
- `hit_ready`=0, press button 1 three times (each debounced): first in output, second pending, third → `ovf`=1; `ovf_clr` → 0; `flush` → `hit_valid`=0.
- `arm`=0, press button 2 → `btn_level[2]` follows, no event; `arm`=1 while still held → no event until re-press.
